// File: rtl/if_pkg.sv
// Shared constants, FSM encoding and IF/ID record for the instruction-fetch stage.
package if_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    localparam int unsigned OPCODE_LSB = 2;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned REG_W      = 5;

    // IF/ID record carries the widest supported PC; narrower cores use the low bits.
    localparam int unsigned PC_MAX_W   = 64;

    typedef enum logic [2:0] {
        StIssue,
        StFetch,
        StHold,
        StPcWait,
        StDiscard
    } if_state_t;

    typedef struct packed {
        logic                valid;
        logic [31:0]         instr;
        logic [PC_MAX_W-1:0] pc;
    } if_id_t;

    function automatic logic [REG_W-1:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [REG_W-1:0] rs1_of(input logic [31:0] instr);
        return instr[RS1_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] rs2_of(input logic [31:0] instr);
        return instr[RS2_LSB +: REG_W];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface if_stage_if #(
    parameter int unsigned XLEN = 32
);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush/bubble insert a NOP, load captures a word, otherwise hold.
module if_id_reg
    import if_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                bubble_i,
    input  logic                load_i,
    input  logic [31:0]         instr_i,
    input  logic [PC_MAX_W-1:0] pc_i,
    output if_id_t              if_id_o
);

    if_id_t if_id_d, if_id_q;

    always_comb begin
        if_id_d = if_id_q;
        // Bubbles and flushes keep the old PC so ID still sees a sensible value.
        if (flush_i || bubble_i) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end else if (load_i) begin
            if_id_d.valid = 1'b1;
            if_id_d.instr = instr_i;
            if_id_d.pc    = pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0};
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id_o = if_id_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requests and the IF/ID register.
// Define IF_STAGE_PERF_EN to add saturating fetched/bubble performance counters.
module if_stage
    import if_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PcWriteEn,
    input  logic             IF_ID_WriteEn,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    if_stage_if.master       imem,
    output logic             IF_ID_Valid,
    output logic [31:0]      IF_ID_Instr,
    output logic [XLEN-1:0]  IF_ID_Pc,
    output logic [REG_W-1:0] ID_Opcode,
    output logic [REG_W-1:0] ID_Rs1,
    output logic [REG_W-1:0] ID_Rs2
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_bubbles
`endif
);

    if_state_t     state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     buf_q, buf_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_tgt;
    logic [31:0]     word;
    logic            word_avail;
    logic            accept;
    logic            bubble;
    logic            b2b_issue;
    logic            outstanding;
    if_id_t          if_id_q;

    assign pc_plus4     = pc_q + XLEN'(4);
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

    assign word_avail  = ((state_q == StFetch) && imem.imem_rvalid) || (state_q == StHold);
    assign word        = (state_q == StHold) ? buf_q : imem.imem_rdata;
    assign accept      = word_avail && IF_ID_WriteEn && !redirect_valid;
    assign bubble      = IF_ID_WriteEn && !accept && !redirect_valid;
    assign b2b_issue   = accept && PcWriteEn && (state_q == StFetch);
    assign outstanding = (state_q == StFetch) || (state_q == StDiscard);

    // Request is gated by reset so nothing is issued while the core is held.
    assign imem.imem_req  = rst_n && !redirect_valid && ((state_q == StIssue) || b2b_issue);
    assign imem.imem_addr = b2b_issue ? pc_plus4 : pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        if (redirect_valid) begin
            pc_d    = redirect_tgt;
            buf_d   = NOP_INSTR;
            state_d = (outstanding && !imem.imem_rvalid) ? StDiscard : StIssue;
        end else begin
            unique case (state_q)
                StIssue: state_d = StFetch;
                StFetch: begin
                    if (imem.imem_rvalid) begin
                        if (!IF_ID_WriteEn) begin
                            buf_d   = imem.imem_rdata;
                            state_d = StHold;
                        end else if (PcWriteEn) begin
                            pc_d = pc_plus4;
                        end else begin
                            state_d = StPcWait;
                        end
                    end
                end
                StHold: begin
                    if (IF_ID_WriteEn) begin
                        if (PcWriteEn) begin
                            pc_d    = pc_plus4;
                            state_d = StIssue;
                        end else begin
                            state_d = StPcWait;
                        end
                    end
                end
                StPcWait: begin
                    if (PcWriteEn) begin
                        pc_d    = pc_plus4;
                        state_d = StIssue;
                    end
                end
                StDiscard: begin
                    if (imem.imem_rvalid) begin
                        state_d = StIssue;
                    end
                end
                default: state_d = StIssue;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIssue;
            pc_q    <= RESET_PC;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (redirect_valid),
        .bubble_i (bubble),
        .load_i   (accept),
        .instr_i  (word),
        .pc_i     (PC_MAX_W'(pc_q)),
        .if_id_o  (if_id_q)
    );

    assign IF_ID_Valid = if_id_q.valid;
    assign IF_ID_Instr = if_id_q.instr;
    assign IF_ID_Pc    = if_id_q.pc[XLEN-1:0];
    assign ID_Opcode   = opcode_of(if_id_q.instr);
    assign ID_Rs1      = rs1_of(if_id_q.instr);
    assign ID_Rs2      = rs2_of(if_id_q.instr);

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    if (XLEN < PC_MAX_W) begin : g_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = ^if_id_q.pc[PC_MAX_W-1:XLEN];
    end

`ifdef IF_STAGE_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (accept) begin
                perf_fetched_q <= sat_inc(perf_fetched_q);
            end
            if (bubble || redirect_valid) begin
                perf_bubbles_q <= sat_inc(perf_bubbles_q);
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: behavioural imem, program-order model of IF/ID deliveries.
module tb_if_stage;

    localparam int unsigned XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_we, ifid_we, redir;
    logic [31:0] redir_pc;
    logic        valid;
    logic [31:0] instr, ifpc;
    logic [4:0]  opc, rs1, rs2;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    if_stage_if #(.XLEN(XLEN)) bus ();

    if_stage #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PcWriteEn      (pc_we),
        .IF_ID_WriteEn  (ifid_we),
        .redirect_valid (redir),
        .redirect_pc    (redir_pc),
        .imem           (bus),
        .IF_ID_Valid    (valid),
        .IF_ID_Instr    (instr),
        .IF_ID_Pc       (ifpc),
        .ID_Opcode      (opc),
        .ID_Rs1         (rs1),
        .ID_Rs2         (rs2)
`ifdef IF_STAGE_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A3C_96E1 ^ {a[15:0], a[31:16]};
    endfunction

    // Reference program order: consecutive PCs from reset or from the last redirect target.
    exp_t        exp_q[$];
    logic [31:0] seed_pc;

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{pc: seed_pc, instr: mem_word(seed_pc)});
            seed_pc = seed_pc + 32'd4;
        end
    endtask

    // Behavioural instruction memory.
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    bit          mem_rand = 1'b0;

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
            if (!rst_n) begin
                mem_pend = 1'b0;
            end else if (mem_pend) begin
                if (mem_cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(mem_addr);
                    mem_pend        = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            @(negedge clk);
            #1;
            if (rst_n && bus.imem_req) begin
                mem_pend = 1'b1;
                mem_addr = bus.imem_addr;
                mem_cnt  = (mem_rand ? int'($urandom_range(3, 1)) : mem_lat) - 1;
            end
        end
    end

    // Monitor: judges IF/ID after each edge and the request protocol.
    logic        prev_we, prev_redir, p_valid;
    logic [31:0] p_instr, p_pc;
    int          outstanding, idle, total_deliv = 0;
    int          model_fetched, model_bubbles;
    exp_t        mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_req", 32'(bus.imem_req), 32'd0);
                check("rst_valid", 32'(valid), 32'd0);
                check("rst_instr", instr, NOP);
                check("rst_pc", ifpc, 32'd0);
                prev_we = 1'b0; prev_redir = 1'b0; p_valid = 1'b0;
                p_instr = NOP; p_pc = 32'd0; outstanding = 0; idle = 0;
                model_fetched = 0; model_bubbles = 0;
                continue;
            end
            idle++;
            if (prev_redir) begin
                check("flush_valid", 32'(valid), 32'd0);
                check("flush_instr", instr, NOP);
                model_bubbles++;
            end else if (prev_we) begin
                if (valid) begin
                    model_fetched++;
                    total_deliv++;
                    idle = 0;
                    if (exp_q.size() == 0) begin
                        check("sb_nonempty", 32'd0, 32'd1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("deliv_pc", ifpc, mon_e.pc);
                        check("deliv_instr", instr, mon_e.instr);
                        check("id_opcode", 32'(opc), 32'(mon_e.instr[6:2]));
                        check("id_rs1", 32'(rs1), 32'(mon_e.instr[19:15]));
                        check("id_rs2", 32'(rs2), 32'(mon_e.instr[24:20]));
                    end
                end else begin
                    check("bubble_instr", instr, NOP);
                    check("bubble_pc", ifpc, p_pc);
                    model_bubbles++;
                end
            end else begin
                check("hold_valid", 32'(valid), 32'(p_valid));
                check("hold_instr", instr, p_instr);
                check("hold_pc", ifpc, p_pc);
            end
            if (idle > 200) begin
                check("progress", 32'(idle), 32'd0);
                idle = 0;
            end
            if (bus.imem_req) begin
                check("one_outstanding", 32'(outstanding - int'(bus.imem_rvalid)), 32'd0);
                check("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
            end
            outstanding = outstanding - int'(bus.imem_rvalid) + int'(bus.imem_req);
            if (outstanding < 0) outstanding = 0;
            prev_we = ifid_we; prev_redir = redir;
            p_valid = valid; p_instr = instr; p_pc = ifpc;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        ifid_we = 1'b1; pc_we = 1'b1; redir = 1'b0; redir_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        seed_pc = RST_PC;
        refill();
    endtask

    // One cycle starting at posedge+1; returns request/valid observed mid-cycle.
    task automatic cycle(input logic we, input logic pwe, input logic rv, input logic [31:0] rpc,
                         output logic req, output logic [31:0] addr, output logic vld);
        ifid_we = we; pc_we = pwe; redir = rv; redir_pc = rpc;
        @(negedge clk);
        #1;
        req = bus.imem_req; addr = bus.imem_addr; vld = valid;
        if (rv) begin
            exp_q.delete();
            seed_pc = {rpc[31:2], 2'b00};
        end
        refill();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        rq, vl;
        logic [31:0] ad, rpc;
        logic        we, pwe, rv;

        do_reset();
        // Straight-line fetch with a 1-cycle memory.
        cycle(1, 1, 0, 0, rq, ad, vl); check("c1_req", 32'(rq), 1); check("c1_addr", ad, 32'h100);
        cycle(1, 1, 0, 0, rq, ad, vl); check("c2_addr", ad, 32'h104); check("c2_vld", 32'(vl), 0);
        cycle(1, 1, 0, 0, rq, ad, vl); check("c3_addr", ad, 32'h108); check("c3_vld", 32'(vl), 1);
        // IF/ID stalled while a response arrives.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, rq, ad, vl); check("hold_noreq", 32'(rq), 0);
        end
        cycle(1, 1, 0, 0, rq, ad, vl); check("hold_accept_noreq", 32'(rq), 0);
        cycle(1, 1, 0, 0, rq, ad, vl); check("after_hold_addr", ad, 32'h10C);
        // PC frozen after accept.
        cycle(1, 0, 0, 0, rq, ad, vl); check("pcwait_noreq0", 32'(rq), 0);
        cycle(1, 0, 0, 0, rq, ad, vl); check("pcwait_noreq1", 32'(rq), 0);
        cycle(1, 1, 0, 0, rq, ad, vl); check("pcwait_release_noreq", 32'(rq), 0);
        mem_lat = 3;
        cycle(1, 1, 0, 0, rq, ad, vl); check("pcwait_next_addr", ad, 32'h110);
        // Redirect while the request is outstanding.
        cycle(1, 1, 1, 32'h203, rq, ad, vl); check("redir_noreq", 32'(rq), 0);
        mem_lat = 1;
        cycle(1, 1, 0, 0, rq, ad, vl); check("discard_noreq0", 32'(rq), 0);
        cycle(1, 1, 0, 0, rq, ad, vl); check("discard_noreq1", 32'(rq), 0);
        cycle(1, 1, 0, 0, rq, ad, vl); check("redir_addr", ad, 32'h200);
        // Wrap at the top of the address space.
        cycle(1, 1, 1, 32'hFFFF_FFFC, rq, ad, vl); check("redir2_noreq", 32'(rq), 0);
        cycle(1, 1, 0, 0, rq, ad, vl); check("wrap_addr0", ad, 32'hFFFF_FFFC);
        cycle(1, 1, 0, 0, rq, ad, vl);
        check("wrap_req", 32'(rq), 1); check("wrap_addr1", ad, 32'h0);
        repeat (3) cycle(1, 1, 0, 0, rq, ad, vl);

        // Randomized stalls, redirects and memory latency.
        mem_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            we  = ($urandom_range(9, 0) < 8);
            pwe = ($urandom_range(9, 0) < 8);
            rv  = ($urandom_range(15, 0) == 0);
            rpc = $urandom;
            if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
            cycle(we, pwe, rv, rpc, rq, ad, vl);
        end
        repeat (20) cycle(1, 1, 0, 0, rq, ad, vl);
        check("progress_total", 32'(total_deliv > 300), 1);

        // Reset with traffic in flight, then restart from the reset PC.
        do_reset();
        cycle(1, 1, 0, 0, rq, ad, vl);
        check("rerst_req", 32'(rq), 1); check("rerst_addr", ad, RST_PC);
        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom_range(1, 0)), 1, 1'($urandom_range(19, 0) == 0), $urandom,
                  rq, ad, vl);
        end
        repeat (10) cycle(1, 1, 0, 0, rq, ad, vl);
`ifdef IF_STAGE_PERF_EN
        check("perf_fetched", perf_fetched, 32'(model_fetched));
        check("perf_bubbles", perf_bubbles, 32'(model_bubbles));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
